wb_master_arbiter: RTL and testbench

Multi-master Wishbone arbiter that shares the single internal bus between `NUM_MASTER` requesters ahead of the address-decode mux. It selects one master per bus tenure, using either round-robin or fixed priority as chosen by `roundORpriority`. It holds the grant for the whole `cyc` tenure, so bursts and RMW sequences are never split. It forwards the granted master's bundle to the shared bus, returns `ack`/`err`/`rty` only to the owner, and aborts hung tenures with a watchdog `err`.

---
 rtl/wb_master_arbiter.sv | 168 ++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
// Wishbone multi-master arbiter: one owner per cyc tenure, round-robin or fixed
// priority selection, owner-only terminations and a stalled-strobe watchdog.
module wb_master_arbiter #(
   parameter int DW         = 32,
   parameter int AW         = 32,
   parameter int NUM_MASTER = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    roundORpriority,
   input  logic [NUM_MASTER*AW-1:0] wbm_adr_i,
   input  logic [NUM_MASTER*DW-1:0] wbm_dat_i,
   input  logic [NUM_MASTER*4-1:0]  wbm_sel_i,
   input  logic [NUM_MASTER*3-1:0]  wbm_cti_i,
   input  logic [NUM_MASTER*2-1:0]  wbm_bte_i,
   input  logic [NUM_MASTER-1:0]    wbm_we_i,
   input  logic [NUM_MASTER-1:0]    wbm_stb_i,
   input  logic [NUM_MASTER-1:0]    wbm_cyc_i,
   output logic [NUM_MASTER-1:0]    wbm_ack_o,
   output logic [NUM_MASTER-1:0]    wbm_err_o,
   output logic [NUM_MASTER-1:0]    wbm_rty_o,
   output logic [NUM_MASTER*DW-1:0] wbm_dat_o,
   output logic [AW-1:0]            o_adr,
   output logic [DW-1:0]            o_dat,
   output logic [3:0]               o_sel,
   output logic [2:0]               o_cti,
   output logic [1:0]               o_bte,
   output logic                     o_we,
   output logic                     o_stb,
   output logic                     o_cyc,
   input  logic                     i_ack,
   input  logic                     i_err,
   input  logic                     i_rty,
   input  logic [DW-1:0]            s_dat_i,
   output logic [NUM_MASTER-1:0]    o_grant,
   output logic                     o_timeout
);

   localparam int IW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [NUM_MASTER-1:0] GRANT_ONE = NUM_MASTER'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_ABORT} state_t;

   state_t        state;
   logic [IW-1:0] owner;
   logic [IW-1:0] last;
   logic [CW-1:0] cnt;
   logic [IW-1:0] pick;
   logic [IW-1:0] cand;
   logic          found;
   logic          stalled;

   // NOTE: every variable written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      pick  = '0;
      cand  = '0;
      found = 1'b0;
      if (roundORpriority) begin
         for (int i = 0; i < NUM_MASTER; i++) begin
            if (!found && wbm_cyc_i[i]) begin
               pick  = IW'(i);
               found = 1'b1;
            end
         end
      end else begin
         // Round-robin search starts just after the previous winner and wraps.
         for (int k = 1; k <= NUM_MASTER; k++) begin
            cand = IW'((int'(last) + k) % NUM_MASTER);
            if (!found && wbm_cyc_i[cand]) begin
               pick  = cand;
               found = 1'b1;
            end
         end
      end
   end

   assign stalled = (state == ST_OWN) && o_stb && !(i_ack || i_err || i_rty);

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order. All control
   // registers are cleared by the asynchronous reset; there is no memory here.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state     <= ST_IDLE;
         o_grant   <= '0;
         owner     <= '0;
         last      <= IW'(NUM_MASTER - 1);
         cnt       <= '0;
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (|wbm_cyc_i) begin
                  o_grant <= GRANT_ONE << pick;
                  owner   <= pick;
                  if (!roundORpriority) last <= pick;
                  state   <= ST_OWN;
               end
            end
            ST_OWN: begin
               if (!wbm_cyc_i[owner]) begin
                  o_grant <= '0;
                  cnt     <= '0;
                  state   <= ST_IDLE;
               end else if (stalled) begin
                  if (cnt == CW'(TIMEOUT - 1)) begin
                     cnt       <= '0;
                     o_timeout <= 1'b1;
                     state     <= ST_ABORT;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end else begin
                  cnt <= '0;
               end
            end
            ST_ABORT: begin
               o_grant <= '0;
               cnt     <= '0;
               state   <= ST_IDLE;
            end
            default: begin
               o_grant <= '0;
               cnt     <= '0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      o_adr     = '0;
      o_dat     = '0;
      o_sel     = '0;
      o_cti     = '0;
      o_bte     = '0;
      o_we      = 1'b0;
      o_stb     = 1'b0;
      o_cyc     = 1'b0;
      wbm_ack_o = '0;
      wbm_err_o = '0;
      wbm_rty_o = '0;
      if (state == ST_OWN) begin
         o_adr            = wbm_adr_i[int'(owner)*AW +: AW];
         o_dat            = wbm_dat_i[int'(owner)*DW +: DW];
         o_sel            = wbm_sel_i[int'(owner)*4 +: 4];
         o_cti            = wbm_cti_i[int'(owner)*3 +: 3];
         o_bte            = wbm_bte_i[int'(owner)*2 +: 2];
         o_we             = wbm_we_i[owner];
         o_stb            = wbm_stb_i[owner];
         o_cyc            = wbm_cyc_i[owner];
         wbm_ack_o[owner] = i_ack;
         wbm_err_o[owner] = i_err;
         wbm_rty_o[owner] = i_rty;
      end else if (state == ST_ABORT) begin
         // The bus is already released; only the forced error reaches the owner.
         wbm_err_o[owner] = 1'b1;
      end
   end

   assign wbm_dat_o = {NUM_MASTER{s_dat_i}};

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed self-checking bench for wb_master_arbiter (2 masters, TIMEOUT=8).
module tb_wb_master_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int NM = 2;
   localparam int TO = 8;

   logic              i_clk;
   logic              i_rst;
   logic              roundORpriority;
   logic [NM*AW-1:0]  wbm_adr_i;
   logic [NM*DW-1:0]  wbm_dat_i;
   logic [NM*4-1:0]   wbm_sel_i;
   logic [NM*3-1:0]   wbm_cti_i;
   logic [NM*2-1:0]   wbm_bte_i;
   logic [NM-1:0]     wbm_we_i;
   logic [NM-1:0]     wbm_stb_i;
   logic [NM-1:0]     wbm_cyc_i;
   logic [NM-1:0]     wbm_ack_o;
   logic [NM-1:0]     wbm_err_o;
   logic [NM-1:0]     wbm_rty_o;
   logic [NM*DW-1:0]  wbm_dat_o;
   logic [AW-1:0]     o_adr;
   logic [DW-1:0]     o_dat;
   logic [3:0]        o_sel;
   logic [2:0]        o_cti;
   logic [1:0]        o_bte;
   logic              o_we;
   logic              o_stb;
   logic              o_cyc;
   logic              i_ack;
   logic              i_err;
   logic              i_rty;
   logic [DW-1:0]     s_dat_i;
   logic [NM-1:0]     o_grant;
   logic              o_timeout;

   int tests_run = 0;
   int tests_failed = 0;

   wb_master_arbiter #(.DW(DW), .AW(AW), .NUM_MASTER(NM), .TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .roundORpriority(roundORpriority),
      .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
      .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i), .wbm_we_i(wbm_we_i),
      .wbm_stb_i(wbm_stb_i), .wbm_cyc_i(wbm_cyc_i),
      .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
      .wbm_dat_o(wbm_dat_o),
      .o_adr(o_adr), .o_dat(o_dat), .o_sel(o_sel), .o_cti(o_cti), .o_bte(o_bte),
      .o_we(o_we), .o_stb(o_stb), .o_cyc(o_cyc),
      .i_ack(i_ack), .i_err(i_err), .i_rty(i_rty), .s_dat_i(s_dat_i),
      .o_grant(o_grant), .o_timeout(o_timeout)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_rst           = 1'b0;
      roundORpriority = 1'b1;
      wbm_adr_i       = {32'hA000_0001, 32'hA000_0000};
      wbm_dat_i       = {32'hD000_0001, 32'hD000_0000};
      wbm_sel_i       = {4'hC, 4'h3};
      wbm_cti_i       = '0;
      wbm_bte_i       = {2'b01, 2'b10};
      wbm_we_i        = 2'b10;
      wbm_stb_i       = 2'b00;
      wbm_cyc_i       = 2'b00;
      i_ack           = 1'b0;
      i_err           = 1'b0;
      i_rty           = 1'b0;
      s_dat_i         = 32'hCAFE_F00D;

      // Reset state
      #2;
      check("rst_grant", 64'(o_grant), 64'h0);
      check("rst_cyc", 64'(o_cyc), 64'h0);
      check("rst_timeout", 64'(o_timeout), 64'h0);
      check("rst_ack", 64'(wbm_ack_o), 64'h0);
      check("rst_adr", 64'(o_adr), 64'h0);
      check("rdata_repl", 64'(wbm_dat_o), 64'hCAFE_F00D_CAFE_F00D);
      step();
      step();
      i_rst = 1'b1;

      // Priority mode, simultaneous requests
      roundORpriority = 1'b1;
      wbm_cyc_i = 2'b11;
      wbm_stb_i = 2'b11;
      #1;
      check("pri_pre_grant", 64'(o_grant), 64'h0);
      check("pri_pre_cyc", 64'(o_cyc), 64'h0);
      step();
      check("pri_grant0", 64'(o_grant), 64'h1);
      check("pri_cyc", 64'(o_cyc), 64'h1);
      check("pri_adr", 64'(o_adr), 64'hA000_0000);
      check("pri_sel", 64'(o_sel), 64'h3);
      check("pri_bte", 64'(o_bte), 64'h2);
      check("pri_we", 64'(o_we), 64'h0);
      i_ack = 1'b1;
      #1;
      check("pri_ack_owner", 64'(wbm_ack_o), 64'h1);
      step();
      i_ack = 1'b0;
      wbm_cyc_i = 2'b10;
      wbm_stb_i = 2'b10;
      #1;
      check("pri_release_cyc", 64'(o_cyc), 64'h0);
      step();
      check("pri_gap", 64'(o_grant), 64'h0);
      step();
      check("pri_grant1", 64'(o_grant), 64'h2);
      check("pri_adr1", 64'(o_adr), 64'hA000_0001);
      check("pri_dat1", 64'(o_dat), 64'hD000_0001);
      check("pri_we1", 64'(o_we), 64'h1);
      wbm_cyc_i = 2'b00;
      wbm_stb_i = 2'b00;
      step();
      check("pri_idle", 64'(o_grant), 64'h0);

      // Round-robin with both masters re-requesting: 01, 10, 01, 10
      roundORpriority = 1'b0;
      wbm_cyc_i = 2'b11;
      wbm_stb_i = 2'b11;
      step();
      check("rr_t1", 64'(o_grant), 64'h1);
      wbm_cyc_i = 2'b10;
      step();
      check("rr_gap1", 64'(o_grant), 64'h0);
      wbm_cyc_i = 2'b11;
      step();
      check("rr_t2", 64'(o_grant), 64'h2);
      wbm_cyc_i = 2'b01;
      step();
      check("rr_gap2", 64'(o_grant), 64'h0);
      wbm_cyc_i = 2'b11;
      step();
      check("rr_t3", 64'(o_grant), 64'h1);
      wbm_cyc_i = 2'b10;
      step();
      wbm_cyc_i = 2'b11;
      step();
      check("rr_t4", 64'(o_grant), 64'h2);
      wbm_cyc_i = 2'b00;
      wbm_stb_i = 2'b00;
      step();
      check("rr_idle", 64'(o_grant), 64'h0);

      // m1 burst while m0 waits (last winner is m1, only m1 requests first)
      wbm_cyc_i = 2'b10;
      wbm_stb_i = 2'b10;
      wbm_cti_i = {3'b010, 3'b000};
      step();
      check("burst_grant", 64'(o_grant), 64'h2);
      wbm_cyc_i = 2'b11;
      wbm_stb_i = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wbm_cti_i = (k == 3) ? {3'b111, 3'b000} : {3'b010, 3'b000};
         i_ack = 1'b1;
         #1;
         check("burst_cti", 64'(o_cti), (k == 3) ? 64'h7 : 64'h2);
         check("burst_ack", 64'(wbm_ack_o), 64'h2);
         check("burst_hold", 64'(o_grant), 64'h2);
         step();
      end
      i_ack = 1'b0;
      wbm_cyc_i = 2'b01;
      wbm_stb_i = 2'b01;
      wbm_cti_i = '0;
      #1;
      check("burst_end_ack", 64'(wbm_ack_o), 64'h0);
      step();
      check("burst_gap", 64'(o_grant), 64'h0);
      step();
      check("burst_m0", 64'(o_grant), 64'h1);
      i_ack = 1'b1;
      #1;
      check("burst_m0_ack", 64'(wbm_ack_o), 64'h1);
      step();
      i_ack = 1'b0;
      wbm_cyc_i = 2'b00;
      wbm_stb_i = 2'b00;
      step();

      // Watchdog: no ack, abort 8 cycles after the first strobe
      wbm_cyc_i = 2'b01;
      wbm_stb_i = 2'b01;
      step();
      check("wd_grant", 64'(o_grant), 64'h1);
      check("wd_s0_to", 64'(o_timeout), 64'h0);
      for (int k = 1; k < TO; k++) begin
         step();
         check("wd_wait_to", 64'(o_timeout), 64'h0);
         check("wd_wait_cyc", 64'(o_cyc), 64'h1);
      end
      step();
      check("wd_fire_to", 64'(o_timeout), 64'h1);
      check("wd_fire_err", 64'(wbm_err_o), 64'h1);
      check("wd_fire_cyc", 64'(o_cyc), 64'h0);
      check("wd_fire_stb", 64'(o_stb), 64'h0);
      step();
      check("wd_idle_grant", 64'(o_grant), 64'h0);
      check("wd_idle_to", 64'(o_timeout), 64'h0);
      check("wd_idle_err", 64'(wbm_err_o), 64'h0);
      step();
      check("wd_regrant", 64'(o_grant), 64'h1);
      wbm_cyc_i = 2'b00;
      wbm_stb_i = 2'b00;
      step();

      // Ack on the 8th stalled cycle wins over the watchdog
      wbm_cyc_i = 2'b01;
      wbm_stb_i = 2'b01;
      step();
      for (int k = 1; k < TO; k++) step();
      i_ack = 1'b1;
      #1;
      check("late_ack", 64'(wbm_ack_o), 64'h1);
      check("late_to", 64'(o_timeout), 64'h0);
      step();
      i_ack = 1'b0;
      #1;
      check("late_no_abort_to", 64'(o_timeout), 64'h0);
      check("late_no_abort_cyc", 64'(o_cyc), 64'h1);
      check("late_no_err", 64'(wbm_err_o), 64'h0);
      wbm_cyc_i = 2'b00;
      wbm_stb_i = 2'b00;
      step();

      // Asynchronous reset mid-tenure, then round-robin restarts at master 0
      wbm_cyc_i = 2'b10;
      wbm_stb_i = 2'b10;
      step();
      check("ar_grant", 64'(o_grant), 64'h2);
      #2;
      i_rst = 1'b0;
      #1;
      check("ar_grant_drop", 64'(o_grant), 64'h0);
      check("ar_cyc_drop", 64'(o_cyc), 64'h0);
      check("ar_no_term", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'h0);
      step();
      wbm_cyc_i = 2'b11;
      wbm_stb_i = 2'b11;
      i_rst = 1'b1;
      #1;
      check("ar_release", 64'(o_grant), 64'h0);
      step();
      check("ar_rr_m0", 64'(o_grant), 64'h1);
      i_rty = 1'b1;
      #1;
      check("ar_rty_owner", 64'(wbm_rty_o), 64'h1);
      i_rty = 1'b0;
      wbm_cyc_i = 2'b00;
      wbm_stb_i = 2'b00;
      step();
      check("final_idle", 64'(o_grant), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
